// File: rtl/fsm_oe8s_sequencer_driver.sv
// Timed driver for an 8-state one-hot sequencer: dwells in each state, pulses the
// matching transition strobe, and watches that the sequencer follows.
module fsm_oe8s_sequencer_driver #(
  parameter int CNT_W  = 8,
  parameter int ACK_TO = 4,
  parameter int LAP_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [8*CNT_W-1:0] dwell,
  input  logic               st0,
  input  logic               st1,
  input  logic               st2,
  input  logic               st3,
  input  logic               st4,
  input  logic               st5,
  input  logic               st6,
  input  logic               st7,
  output logic               t01,
  output logic               t12,
  output logic               t23,
  output logic               t34,
  output logic               t45,
  output logic               t56,
  output logic               t67,
  output logic               t70,
  output logic               busy,
  output logic               err,
  output logic [LAP_W-1:0]   lap_cnt
);

  typedef enum logic [1:0] {IDLE, COUNT, WAIT_ACK, FAULT} state_t;

  localparam int TMR_W = $clog2(ACK_TO + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cur;
  logic [TMR_W-1:0] ack_tmr;
  logic [7:0]       strobe;

  logic [7:0]       st;
  logic [2:0]       idx;
  logic [2:0]       nxt;
  logic             vld;
  logic [CNT_W-1:0] dwell_sel;

  assign st  = {st7, st6, st5, st4, st3, st2, st1, st0};
  assign vld = $onehot(st);
  assign nxt = cur + 3'd1;
  assign dwell_sel = dwell[int'(idx)*CNT_W +: CNT_W];

  assign {t70, t67, t56, t45, t34, t23, t12, t01} = strobe;

  always_comb begin
    // NOTE: default first so every path assigns idx and no latch is inferred.
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (st[i]) idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur     <= '0;
      ack_tmr <= '0;
      strobe  <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      lap_cnt <= '0;
    end else begin
      // NOTE: sequential state uses <= only; the default below makes every strobe one cycle wide.
      strobe  <= '0;
      lap_cnt <= lap_cnt + LAP_W'(strobe[7]);
      case (state)
        IDLE: begin
          if (en) begin
            if (vld) begin
              cnt   <= dwell_sel;
              cur   <= idx;
              state <= COUNT;
              busy  <= 1'b1;
            end else begin
              state <= FAULT;
              err   <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (!vld || idx != cur) begin
            state <= FAULT;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            strobe[cur] <= 1'b1;
            ack_tmr     <= '0;
            state       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A strobe already issued stands; en only picks where we go after the ack.
          if (vld && idx == cur) begin
            ack_tmr <= ack_tmr + 1'b1;
            if (ack_tmr == TMR_W'(ACK_TO - 1)) begin
              state <= FAULT;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end else if (vld && idx == nxt) begin
            cur <= idx;
            if (en) begin
              cnt   <= dwell_sel;
              state <= COUNT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            state <= FAULT;
            busy  <= 1'b0;
            err   <= 1'b1;
          end
        end
        FAULT: begin
          if (!en && clr) begin
            state <= IDLE;
            err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fsm_oe8s_sequencer_driver.md
Name: fsm_oe8s_sequencer_driver

Overview:
- Timed driver for the 8-state one-hot sequencer.
- Inputs are the sequencer's state flags st0..st7. Outputs are its transition strobes t01..t70.
- Holds each state for a programmable dwell, then pulses the matching transition and checks that the sequencer advances.
- Flags protocol faults: non-one-hot state, unexpected jump, or no acknowledge within a timeout.

Parameters:
CNT_W, 8, width of each per-state dwell count
ACK_TO, 4, max cycles after a strobe for the sequencer to show the next state (ACK_TO >= 2)
LAP_W, 16, width of lap counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  run enable
clr  in  1  clear sticky fault (honoured only when en=0)
dwell  in  8*CNT_W  packed dwell counts; dwell[i*CNT_W +: CNT_W] is the count for state i
st0..st7  in  1 each  sequencer state flags
t01,t12,t23,t34,t45,t56,t67,t70  out  1 each  transition strobes, registered, single-cycle
busy  out  1  high in COUNT or WAIT_ACK
err  out  1  sticky fault flag
lap_cnt  out  LAP_W  number of t70 strobes issued, wraps

Behaviour:
- Reset values: all t* = 0, busy = 0, err = 0, lap_cnt = 0, FSM = IDLE, counter = 0. Reset mid-operation aborts immediately; there are no pending strobes.
- Decode: idx = index of the single high st bit. vld = exactly one st bit high.
- FSM states: IDLE, COUNT, WAIT_ACK, FAULT.
- IDLE:
  - en=1 and vld: load cnt = dwell[idx], latch cur = idx, go to COUNT.
  - en=1 and !vld: go to FAULT.
- COUNT:
  - !vld, or idx != cur: go to FAULT.
  - en=0: go to IDLE with no strobe.
  - cnt != 0: cnt decrements.
  - cnt == 0: register strobe t(cur)(cur+1 mod 8) high for the next cycle only, clear ack timer, go to WAIT_ACK.
- WAIT_ACK:
  - idx == cur with vld: ack timer increments. When the timer reaches ACK_TO, go to FAULT.
  - idx == cur+1 mod 8 with vld: accept. cur = idx. If en=1, load cnt = dwell[idx] and go to COUNT; else go to IDLE.
  - Any other value, or !vld: go to FAULT.
  - The en value in this state affects only the post-ack destination. The strobe already issued is never retracted.
- FAULT:
  - err set to 1 (sticky). No strobes. busy = 0.
  - Leaves to IDLE only when en=0 and clr=1, which also clears err.
  - clr while en=1 is ignored.
- Timing with a directly connected sequencer:
  - Each state is held for exactly dwell+3 cycles.
  - Those cycles are: 1 ack cycle, dwell+1 COUNT cycles, and 1 strobe cycle.
  - The first state after enable is held dwell+2 cycles after the first COUNT cycle.
- Strobes: at most one t* high in any cycle. Never two consecutive cycles high.
- lap_cnt: +1 in the cycle t70 is high. Wraps from 2^LAP_W-1 to 0. Cleared only by rst.
- Counter arithmetic: unsigned, CNT_W bits. dwell=0 gives a strobe after exactly 1 COUNT cycle. The dwell input is sampled only at load time.

Test Plan:
1. Sequencer wired back-to-back, all dwell=2, en=1 after reset → t01 strobe 4 cycles after en. Every later state is held 5 cycles. Strobes t01..t70 appear in order. lap_cnt=1 one cycle after the first t70. err=0 throughout.
2. All dwell=0 → each state is held 3 cycles, with one strobe per 3 cycles. dwell[3]=255 with the others 0 → st3 held 258 cycles.
3. Sequencer frozen in st2 after the t23 strobe, ACK_TO=4 → err=1 exactly 4 cycles after the strobe, and no further strobes. en=0 with clr=1 → err=0 and FSM in IDLE next cycle. clr while en=1 → err stays 1.
4. Force st2 and st5 high together during COUNT → err=1 next cycle. Force a jump st2→st4 in WAIT_ACK → err=1.
5. en dropped 1 cycle before cnt reaches 0 → no strobe, IDLE. en reasserted → the full dwell reloads for the same state.
6. en dropped during the t45 strobe cycle → sequencer still reaches st5, driver goes to IDLE with busy=0. Separately, preload 65535 laps (force) → the next t70 makes lap_cnt=0. Assert rst mid-COUNT → all outputs return to their reset values next cycle.
